// File: rtl/instruction_loader.sv
// Instruction bank writer: packs a big-endian byte stream into words, writes them
// from address 0 upward and closes every load with an all-zero terminator word.
module instruction_loader #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int NUM_INSTRUCTIONS  = 1024,
  parameter int ADDR_WIDTH        = $clog2(NUM_INSTRUCTIONS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_valid_i,
  input  logic [7:0]                   rx_data_i,
  input  logic                         rx_last_i,
  output logic                         wr_en_o,
  output logic [ADDR_WIDTH-1:0]        wr_addr_o,
  output logic [INSTRUCTION_WIDTH-1:0] wr_data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [ADDR_WIDTH-1:0]        inst_count_o,
  output logic                         overflow_o,
  output logic                         partial_o
);

  localparam int BYTES = INSTRUCTION_WIDTH / 8;
  localparam int CNT_W = $clog2(BYTES);
  localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_INSTRUCTIONS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ASSEMBLE,
    TERM,
    DONE
  } state_e;

  state_e                         state_q;
  logic [INSTRUCTION_WIDTH-9:0]   shift_q;
  logic [CNT_W-1:0]               byteCnt_q;
  logic [ADDR_WIDTH-1:0]          addr_q;
  logic                           termPend_q;
  logic                           wrEn_q;
  logic [ADDR_WIDTH-1:0]          wrAddr_q;
  logic [INSTRUCTION_WIDTH-1:0]   wrData_q;
  logic [ADDR_WIDTH-1:0]          instCount_q;
  logic                           overflow_q;
  logic                           partial_q;
  logic                           busy_q;
  logic                           done_q;

  logic [INSTRUCTION_WIDTH-1:0]   asmWord_d;
  logic                           wordDone_d;
  logic                           bankFull_d;

  // Only the bytes gathered so far are stored; the incoming byte completes the word.
  assign asmWord_d  = {shift_q, rx_data_i};
  assign wordDone_d = (byteCnt_q == LAST_BYTE);
  assign bankFull_d = (addr_q == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      byteCnt_q   <= '0;
      addr_q      <= '0;
      termPend_q  <= 1'b0;
      wrEn_q      <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      instCount_q <= '0;
      overflow_q  <= 1'b0;
      partial_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wrEn_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (rx_valid_i) begin
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
            overflow_q  <= 1'b0;
            instCount_q <= '0;
            addr_q      <= '0;
            termPend_q  <= 1'b0;
            shift_q     <= (INSTRUCTION_WIDTH - 8)'(rx_data_i);
            byteCnt_q   <= CNT_W'(1);
            if (rx_last_i) begin
              partial_q <= 1'b1;
              wrEn_q    <= 1'b1;
              wrData_q  <= '0;
              wrAddr_q  <= '0;
              state_q   <= TERM;
            end else begin
              partial_q <= 1'b0;
              state_q   <= ASSEMBLE;
            end
          end
        end

        ASSEMBLE: begin
          if (rx_valid_i) begin
            shift_q <= asmWord_d[INSTRUCTION_WIDTH-9:0];
            if (wordDone_d) begin
              byteCnt_q <= '0;
              // The top address is kept free for the terminator.
              if (bankFull_d) begin
                overflow_q <= 1'b1;
              end else begin
                wrEn_q      <= 1'b1;
                wrData_q    <= asmWord_d;
                wrAddr_q    <= addr_q;
                addr_q      <= addr_q + ADDR_WIDTH'(1);
                instCount_q <= instCount_q + ADDR_WIDTH'(1);
              end
            end else begin
              byteCnt_q <= byteCnt_q + CNT_W'(1);
            end
            if (rx_last_i) begin
              state_q <= TERM;
              if (wordDone_d && !bankFull_d) begin
                termPend_q <= 1'b1;
              end else begin
                wrEn_q   <= 1'b1;
                wrData_q <= '0;
                wrAddr_q <= addr_q;
                if (!wordDone_d) begin
                  partial_q <= 1'b1;
                end
              end
            end
          end
        end

        TERM: begin
          // A final word write occupies the first TERM cycle; the terminator follows it.
          if (termPend_q) begin
            termPend_q <= 1'b0;
            wrEn_q     <= 1'b1;
            wrData_q   <= '0;
            wrAddr_q   <= addr_q;
          end else begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en_o      = wrEn_q;
  assign wr_addr_o    = wrAddr_q;
  assign wr_data_o    = wrData_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign inst_count_o = instCount_q;
  assign overflow_o   = overflow_q;
  assign partial_o    = partial_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: two banks (8 and 4 words) share one byte stream and
// every observed write is compared against a frame-level reference model.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxValid;
  logic [7:0]  rxData;
  logic        rxLast;

  logic        wrEn8, busy8, done8, ovf8, part8;
  logic [2:0]  wrAddr8, instCount8;
  logic [31:0] wrData8;
  logic        wrEn4, busy4, done4, ovf4, part4;
  logic [1:0]  wrAddr4, instCount4;
  logic [31:0] wrData4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
    logic        busy;
  } wr_t;

  wr_t        got8[$];
  wr_t        got4[$];
  wr_t        expQ[$];
  logic [7:0] pattern[$];
  logic [7:0] frameBytes[$];
  int         byteCyc[$];
  logic       bothSeen;
  logic       doneQ8, doneQ4;
  int         doneRise8, doneRise4;
  logic       doneAtByte;
  int         expCnt, expDone;
  logic       expOvf, expPart;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  instruction_loader #(.INSTRUCTION_WIDTH(32), .NUM_INSTRUCTIONS(8)) dut8 (
    .clk(clk), .rst(rst), .rx_valid_i(rxValid), .rx_data_i(rxData), .rx_last_i(rxLast),
    .wr_en_o(wrEn8), .wr_addr_o(wrAddr8), .wr_data_o(wrData8), .busy_o(busy8),
    .done_o(done8), .inst_count_o(instCount8), .overflow_o(ovf8), .partial_o(part8)
  );

  instruction_loader #(.INSTRUCTION_WIDTH(32), .NUM_INSTRUCTIONS(4)) dut4 (
    .clk(clk), .rst(rst), .rx_valid_i(rxValid), .rx_data_i(rxData), .rx_last_i(rxLast),
    .wr_en_o(wrEn4), .wr_addr_o(wrAddr4), .wr_data_o(wrData4), .busy_o(busy4),
    .done_o(done4), .inst_count_o(instCount4), .overflow_o(ovf4), .partial_o(part4)
  );

  // Bank-side monitor: log every write cycle and the cycle where done rises.
  always @(negedge clk) begin : monitor
    wr_t rec;
    if (wrEn8 === 1'b1) begin
      rec.addr = int'(wrAddr8); rec.data = wrData8; rec.cyc = cyc; rec.busy = busy8;
      got8.push_back(rec);
    end
    if (wrEn4 === 1'b1) begin
      rec.addr = int'(wrAddr4); rec.data = wrData4; rec.cyc = cyc; rec.busy = busy4;
      got4.push_back(rec);
    end
    if ((busy8 === 1'b1 && done8 === 1'b1) || (busy4 === 1'b1 && done4 === 1'b1)) bothSeen = 1'b1;
    if (done8 === 1'b1 && doneQ8 === 1'b0) doneRise8 = cyc;
    if (done4 === 1'b1 && doneQ4 === 1'b0) doneRise4 = cyc;
    doneQ8 = done8;
    doneQ4 = done4;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic startFrame();
    frameBytes.delete();
    byteCyc.delete();
    got8.delete();
    got4.delete();
    bothSeen  = 1'b0;
    doneRise8 = -1;
    doneRise4 = -1;
  endtask

  task automatic loadWord(input logic [31:0] w);
    pattern.push_back(w[31:24]);
    pattern.push_back(w[23:16]);
    pattern.push_back(w[15:8]);
    pattern.push_back(w[7:0]);
  endtask

  // Present one byte for one cycle, then idle for a random gap with junk on the bus.
  task automatic applyStimulus(input logic [7:0] b, input logic last, input int gapMin, input int gapMax);
    int g;
    rxValid = 1'b1;
    rxData  = b;
    rxLast  = last;
    frameBytes.push_back(b);
    byteCyc.push_back(cyc);
    @(negedge clk);
    doneAtByte = done8;
    @(posedge clk);
    #1;
    rxValid = 1'b0;
    rxLast  = 1'($urandom);
    rxData  = 8'($urandom);
    g = int'($urandom_range(gapMax, gapMin));
    for (int k = 0; k < g; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendPattern(input int gapMin, input int gapMax);
    for (int i = 0; i < pattern.size(); i++) begin
      applyStimulus(pattern[i], 1'(i == pattern.size() - 1), gapMin, gapMax);
    end
  endtask

  task automatic waitDone();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8 === 1'b1 && done4 === 1'b1) break;
    end
    checkOutput("doneTimeout", 64'(done8 === 1'b1 && done4 === 1'b1), 64'(1));
    @(posedge clk);
    #1;
  endtask

  // Frame-level reference: whole words in order, top address reserved for the terminator.
  task automatic buildExpected(input int n);
    wr_t rec;
    int  len, nWords, nWr, lastCyc, termCyc;
    expQ.delete();
    len     = frameBytes.size();
    nWords  = len / 4;
    nWr     = (nWords < n - 1) ? nWords : n - 1;
    lastCyc = byteCyc[len-1];
    for (int i = 0; i < nWr; i++) begin
      rec.addr = i;
      rec.data = {frameBytes[4*i], frameBytes[4*i+1], frameBytes[4*i+2], frameBytes[4*i+3]};
      rec.cyc  = byteCyc[4*i+3] + 1;
      rec.busy = 1'b1;
      expQ.push_back(rec);
    end
    termCyc  = ((len % 4 == 0) && (nWords <= n - 1)) ? lastCyc + 2 : lastCyc + 1;
    rec.addr = nWr;
    rec.data = 32'h0;
    rec.cyc  = termCyc;
    rec.busy = 1'b1;
    expQ.push_back(rec);
    expCnt  = nWr;
    expOvf  = (nWords > n - 1);
    expPart = (len % 4 != 0);
    expDone = termCyc + 1;
  endtask

  task automatic compareDut(input int n);
    wr_t g;
    int  gs, m;
    buildExpected(n);
    gs = (n == 8) ? got8.size() : got4.size();
    checkOutput($sformatf("n%0d_writeCount", n), 64'(gs), 64'(expQ.size()));
    m = (gs < expQ.size()) ? gs : expQ.size();
    for (int i = 0; i < m; i++) begin
      g = (n == 8) ? got8[i] : got4[i];
      checkOutput($sformatf("n%0d_w%0d_addr", n, i), 64'(g.addr), 64'(expQ[i].addr));
      checkOutput($sformatf("n%0d_w%0d_data", n, i), 64'(g.data), 64'(expQ[i].data));
      checkOutput($sformatf("n%0d_w%0d_cycle", n, i), 64'(g.cyc), 64'(expQ[i].cyc));
      checkOutput($sformatf("n%0d_w%0d_busy", n, i), 64'(g.busy), 64'(expQ[i].busy));
    end
    checkOutput($sformatf("n%0d_instCount", n), (n == 8) ? 64'(instCount8) : 64'(instCount4), 64'(expCnt));
    checkOutput($sformatf("n%0d_overflow", n), (n == 8) ? 64'(ovf8) : 64'(ovf4), 64'(expOvf));
    checkOutput($sformatf("n%0d_partial", n), (n == 8) ? 64'(part8) : 64'(part4), 64'(expPart));
    checkOutput($sformatf("n%0d_done", n), (n == 8) ? 64'(done8) : 64'(done4), 64'(1));
    checkOutput($sformatf("n%0d_busyIdle", n), (n == 8) ? 64'(busy8) : 64'(busy4), 64'(0));
    checkOutput($sformatf("n%0d_doneCycle", n), (n == 8) ? 64'(doneRise8) : 64'(doneRise4), 64'(expDone));
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_wrEn"}, 64'(wrEn8), 64'(0));
    checkOutput({tag, "_wrAddr"}, 64'(wrAddr8), 64'(0));
    checkOutput({tag, "_wrData"}, 64'(wrData8), 64'(0));
    checkOutput({tag, "_busy"}, 64'(busy8), 64'(0));
    checkOutput({tag, "_done"}, 64'(done8), 64'(0));
    checkOutput({tag, "_instCount"}, 64'(instCount8), 64'(0));
    checkOutput({tag, "_overflow"}, 64'(ovf8), 64'(0));
    checkOutput({tag, "_partial"}, 64'(part8), 64'(0));
    checkOutput({tag, "_n4_flags"}, 64'({wrEn4, busy4, done4, ovf4, part4, instCount4}), 64'(0));
  endtask

  task automatic runPattern(input int gapMin, input int gapMax);
    startFrame();
    sendPattern(gapMin, gapMax);
    waitDone();
    compareDut(8);
    compareDut(4);
    checkOutput("busyDoneExclusive", 64'(bothSeen), 64'(0));
  endtask

  initial begin
    int len;
    rst     = 1'b1;
    rxValid = 1'b0;
    rxData  = 8'h00;
    rxLast  = 1'b0;
    doneQ8  = 1'b0;
    doneQ4  = 1'b0;
    startFrame();

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] two full words, gapless");
    pattern.delete();
    loadWord(32'h11223344);
    loadWord(32'h55667788);
    runPattern(0, 0);

    $display("[TB] six-byte frame ending mid-word");
    pattern.delete();
    loadWord(32'hAABBCCDD);
    pattern.push_back(8'hEE);
    pattern.push_back(8'hFF);
    runPattern(0, 0);

    $display("[TB] five random words overflow the small bank");
    pattern.delete();
    for (int i = 0; i < 5; i++) loadWord($urandom);
    runPattern(0, 0);

    $display("[TB] same two words with fixed idle gaps");
    pattern.delete();
    loadWord(32'h11223344);
    loadWord(32'h55667788);
    runPattern(2, 2);

    $display("[TB] all-zero word written as an ordinary word");
    pattern.delete();
    loadWord(32'h00000000);
    loadWord(32'hDEADBEEF);
    pattern.push_back(8'h5A);
    runPattern(0, 1);

    $display("[TB] random frames with random gaps");
    for (int f = 0; f < 8; f++) begin
      pattern.delete();
      len = int'($urandom_range(40, 1));
      for (int i = 0; i < len; i++) pattern.push_back(8'($urandom));
      runPattern(0, 2);
    end

    $display("[TB] reset after six bytes of an eight-byte frame");
    startFrame();
    for (int i = 0; i < 6; i++) applyStimulus(8'($urandom), 1'b0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset("midReset");
    checkOutput("midReset_writes8", 64'(got8.size()), 64'(1));
    checkOutput("midReset_writes4", 64'(got4.size()), 64'(1));
    if (got8.size() > 0) begin
      checkOutput("midReset_w0addr", 64'(got8[0].addr), 64'(0));
      checkOutput("midReset_w0data", 64'(got8[0].data),
                  64'({frameBytes[0], frameBytes[1], frameBytes[2], frameBytes[3]}));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    pattern.delete();
    loadWord($urandom);
    runPattern(0, 0);

    $display("[TB] second load straight from DONE");
    startFrame();
    applyStimulus(8'h01, 1'b0, 0, 0);
    checkOutput("doneHeldAtFirstByte", 64'(doneAtByte), 64'(1));
    @(negedge clk);
    checkOutput("doneDropsNextCycle", 64'(done8), 64'(0));
    checkOutput("busyRisesNextCycle", 64'(busy8), 64'(1));
    @(posedge clk);
    #1;
    applyStimulus(8'h02, 1'b0, 0, 0);
    applyStimulus(8'h03, 1'b0, 0, 0);
    applyStimulus(8'h04, 1'b1, 0, 0);
    waitDone();
    compareDut(8);
    compareDut(4);
    checkOutput("reload_w0data", 64'(got8.size() > 0 ? got8[0].data : 32'hFFFFFFFF), 64'(32'h01020304));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the instruction bank: receives a byte stream of the program (network receive path), packs bytes into instruction words and drives the bank's write port at sequential addresses starting at 0.
- After the last byte it writes one all-zero terminator word, which the fetch side treats as end-of-render.
- Holds `busy` high while loading so the core keeps fetch stalled or in reset until `done`.

Parameters:
- INSTRUCTION_WIDTH, 32: instruction word width in bits; must be a multiple of 8 and at least 16.
- NUM_INSTRUCTIONS, 1024: instruction bank depth in words.
- ADDR_WIDTH, $clog2(NUM_INSTRUCTIONS): width of `wr_addr` and `inst_count`.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  `rx_data` is valid this cycle; no backpressure, every valid byte must be consumed or deliberately dropped
- rx_data  in  8  program byte; first byte of each word is the MSB (big-endian)
- rx_last  in  1  qualifies the final byte of the frame; meaningful only when `rx_valid`=1
- wr_en  out  1  instruction bank write enable
- wr_addr  out  ADDR_WIDTH  instruction bank write address
- wr_data  out  INSTRUCTION_WIDTH  instruction bank write data
- busy  out  1  load in progress (states ASSEMBLE or TERM)
- done  out  1  terminator written; bank contents are valid
- inst_count  out  ADDR_WIDTH  non-terminator words written in the current or last load
- overflow  out  1  sticky per load: complete words dropped because the bank was full
- partial  out  1  sticky per load: frame ended with an incomplete word

Behaviour:
- BYTES = INSTRUCTION_WIDTH/8.
- Reset values:
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0
  - `busy`=0, `done`=0, `inst_count`=0, `overflow`=0, `partial`=0
  - byte counter and address counter = 0
  - state = IDLE
- Reset mid-load aborts immediately; words already written stay in the RAM; no terminator is written.
- State IDLE:
  - `rx_valid`=1 clears `done`, `overflow`, `partial` and `inst_count`, and sets the address counter to 0.
  - That byte is accepted as byte 0 of word 0. Go to ASSEMBLE, or directly to TERM if `rx_last` is also 1.
- State ASSEMBLE:
  - Each valid byte shifts into the shift register (shift left 8, new byte at LSB) and the byte counter increments.
  - When the byte counter reaches BYTES-1 on an accepted byte (cycle N), the word is complete:
    - In cycle N+1: `wr_en`=1, `wr_data`=assembled word, `wr_addr`=address counter.
    - The address counter and `inst_count` increment in cycle N+1.
    - The byte counter wraps to 0.
  - Write latency is exactly 1 cycle after the completing byte. Back-to-back complete words are impossible for BYTES≥2, so at most one write is pending.
  - All-zero words in the stream are written as ordinary words.
  - Bank full: address NUM_INSTRUCTIONS-1 is reserved for the terminator. A completed word while the address counter == NUM_INSTRUCTIONS-1 is not written; set `overflow` and leave the address counter unchanged. Bytes continue to be consumed until `rx_last`.
  - `rx_last` on a byte:
    - If that byte completes a word, perform the word write (subject to the full rule), then go to TERM.
    - Otherwise discard the partial bytes, set `partial`, and go to TERM.
- State TERM (one cycle, entered in the cycle after the `rx_last` byte):
  - If a word write is pending, it occurs this cycle and the terminator is written the following cycle. TERM therefore lasts 1 or 2 cycles.
  - Terminator write: `wr_en`=1, `wr_data`=0, `wr_addr`=address counter (≤ NUM_INSTRUCTIONS-1 by construction).
  - `inst_count` does not increment for the terminator. Go to DONE.
  - Bytes arriving in TERM are dropped.
- State DONE:
  - `done`=1, `busy`=0.
  - A valid byte starts a new load exactly as in IDLE: `done` drops the cycle after that byte.
- `wr_en` is high for exactly one cycle per write; `wr_data` and `wr_addr` are don't-care when `wr_en`=0 but must be held at their last values.
- `busy` = state in {ASSEMBLE, TERM}; `busy` and `done` are never both 1.

Test Plan:
- INSTRUCTION_WIDTH=32, NUM_INSTRUCTIONS=8. Bytes 11 22 33 44 55 66 77 88 with `rx_last` on 88 → writes:
  - addr0=0x11223344, one cycle after byte 44
  - addr1=0x55667788
  - addr2=0x00000000
  - then `done`=1, `inst_count`=2, `overflow`=0, `partial`=0
- Frame of 6 bytes AA BB CC DD EE FF, `rx_last` on FF → addr0=0xAABBCCDD, addr1=0 terminator; `partial`=1, `inst_count`=1.
- NUM_INSTRUCTIONS=4, 5 full words W0..W4 → W0..W2 at addr0..2, terminator at addr3; `overflow`=1, `inst_count`=3, W3/W4 never written.
- Bytes with idle gaps (`rx_valid` toggling 1,0,0,1,...) → identical write data and addresses as gapless; `wr_en` pulses exactly once per word.
- Assert `rst` after 6 bytes of an 8-byte frame → no further `wr_en`, all outputs at reset values. A new 4-byte frame then writes at addr0 plus terminator at addr1.
- After DONE, second frame of 4 bytes 01 02 03 04 → `done` falls the cycle after byte 01; writes addr0=0x01020304, addr1=0; `done`=1, `inst_count`=1, flags cleared.
